// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing for the 5-stage core: resolves the hazards that operand
// forwarding cannot (load-use, taken branch, data-memory wait), guards long
// memory waits with a watchdog and keeps saturating stall/flush counters.
module hazard_stall_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_RS1,
  input  logic [4:0]       IF_ID_RS2,
  input  logic [4:0]       ID_EX_RD,
  input  logic             ID_EX_MemRead,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Flush,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;

  logic mem_stall;
  logic load_use;
  logic live;
  logic stall_inc;
  logic flush_inc;

  // x0 is hard-wired zero, so a load targeting it can never feed ID.
  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ID_EX_MemRead & (ID_EX_RD != 5'd0) &
                     ((ID_EX_RD == IF_ID_RS1) | (ID_EX_RD == IF_ID_RS2));

  // ERROR freezes the counters; only RUN and MEM_WAIT cycles are accounted.
  assign live      = (state_reg != ERROR);
  assign stall_inc = live & (mem_stall | (load_use & ~branch_taken));
  assign flush_inc = (state_reg == RUN) & branch_taken & ~mem_stall;

  assign mem_error = (state_reg == ERROR);

  // State and wait-counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next state: track consecutive stalled cycles and trip the watchdog once
  // the counter already equals the limit and the access is still pending.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        if (mem_stall) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end else begin
          wait_cnt_next = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt_reg == WAIT_LIMIT) begin
            state_next = ERROR;
          end else begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
          end
        end else begin
          // Either mem_ready arrived or the request was withdrawn.
          state_next    = RUN;
          wait_cnt_next = '0;
        end
      end
      ERROR: begin
        state_next    = ERROR;
        wait_cnt_next = '0;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Pipeline controls, highest priority first: reset/ERROR kill, memory
  // freeze, branch flush, load-use bubble.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    MEM_WB_Flush = 1'b0;
    if (reset || (state_reg == ERROR)) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      MEM_WB_Flush = 1'b1;
    end else if (mem_stall) begin
      // Hold everything upstream of MEM; EX is re-evaluated after release.
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (branch_taken) begin
      // ID holds a wrong-path instruction, so a load-use match is moot.
      PC_Write    = 1'b1;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (load_use) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  // Saturating stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall_inc && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  // Saturating branch-flush counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_events <= '0;
    end else if (flush_inc && (flush_events != CNT_MAX)) begin
      flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central pipeline sequencing block for the 5-stage RISC-V core.
- Works alongside the EX-stage operand forwarding logic. It covers the hazards that forwarding cannot resolve: load-use stalls, taken-branch flushes, and multi-cycle data-memory waits.
- Drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB write-enable and flush controls.
- Includes a memory-wait watchdog and saturating performance counters.

Parameters:
- MEM_TIMEOUT, 64: max consecutive mem-wait cycles before a fatal error (must be ≥1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- IF_ID_RS1  in  5  rs1 of the instruction in ID
- IF_ID_RS2  in  5  rs2 of the instruction in ID
- ID_EX_RD  in  5  rd of the instruction in EX
- ID_EX_MemRead  in  1  EX instruction is a load
- branch_taken  in  1  EX-stage branch/jump resolved taken this cycle
- mem_req  in  1  MEM stage has a valid load/store
- mem_ready  in  1  data memory completes the MEM-stage access this cycle
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  zero IF/ID (bubble)
- ID_EX_Write  out  1  ID/EX register enable
- ID_EX_Flush  out  1  zero ID/EX control (bubble)
- EX_MEM_Write  out  1  EX/MEM register enable
- MEM_WB_Flush  out  1  insert bubble into MEM/WB
- mem_error  out  1  sticky watchdog error flag
- stall_cycles  out  CNT_W  saturating count of stalled cycles
- flush_events  out  CNT_W  saturating count of branch flushes

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Held in a state register with an asynchronous reset to RUN.
- Derived conditions:
  - mem_stall = mem_req & ~mem_ready
  - load_use = ID_EX_MemRead & (ID_EX_RD≠0) & (ID_EX_RD==IF_ID_RS1 | ID_EX_RD==IF_ID_RS2)
- Control outputs are combinational from state and inputs.
- Default outputs (no hazard): all Write=1, all Flush=0.
- Priority, highest first:
  1. reset or ERROR:
     - all Write=0
     - IF_ID_Flush=ID_EX_Flush=MEM_WB_Flush=1
  2. mem_stall (in RUN or MEM_WAIT), full freeze:
     - PC_Write=IF_ID_Write=ID_EX_Write=EX_MEM_Write=0
     - MEM_WB_Flush=1
     - branch_taken and load_use are ignored; EX contents are held and re-evaluated after release.
  3. branch_taken:
     - IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1.
     - load_use is ignored because the ID instruction is wrong-path.
  4. load_use:
     - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
     - Lasts one cycle: the bubble clears ID_EX_MemRead on the next cycle.
- Transitions:
  - RUN→MEM_WAIT when mem_stall; the wait counter loads 1.
  - MEM_WAIT stays while mem_stall; the wait counter increments.
  - MEM_WAIT→RUN on the cycle after mem_ready=1. In the mem_ready=1 cycle itself, outputs are already released (mem_stall=0).
  - MEM_WAIT→ERROR when mem_stall persists and the wait counter == MEM_TIMEOUT, i.e. after MEM_TIMEOUT+1 consecutive stalled cycles.
  - ERROR is absorbing until reset. mem_error=1 exactly when state==ERROR.
  - A mem_req drop while in MEM_WAIT (mem_stall=0) returns the FSM to RUN, identical to the mem_ready case.
- Wait counter:
  - Width ⌈log2(MEM_TIMEOUT+1)⌉.
  - Cleared in RUN and by reset.
- Performance counters:
  - stall_cycles +1 per clock where (mem_stall | (load_use & ~branch_taken)) in RUN/MEM_WAIT.
  - flush_events +1 per clock where branch_taken & ~mem_stall in RUN.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
  - Both clear to 0 on reset and hold their values in ERROR.
- Reset values: state RUN, mem_error 0, counters 0. While reset=1, outputs follow priority 1.
- Reset asserted mid-MEM_WAIT aborts immediately (asynchronous). The first cycle after deassertion is RUN with default outputs.
- x0 never causes a load-use stall (ID_EX_RD==0 guard).

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_RD=5, IF_ID_RS2=5 for 1 cycle → PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for that cycle; stall_cycles=1; next cycle (MemRead=0) defaults restored.
- x0 / no match: ID_EX_MemRead=1, ID_EX_RD=0, IF_ID_RS1=0 → defaults (no stall); stall_cycles stays 0.
- Branch over load-use: branch_taken=1 together with the load-use match → IF_ID_Flush=ID_EX_Flush=1, PC_Write=1; flush_events=1; stall_cycles=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 →
  - full freeze and MEM_WB_Flush=1 for 3 cycles; branch_taken=1 during the wait has no effect;
  - release in cycle 4; stall_cycles=3; state returns to RUN.
- Watchdog: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held → mem_error rises after 5 stalled cycles, stays 1 with mem_ready=1; reset pulse → mem_error=0, counters 0.
- Reset mid-wait: assert reset asynchronously in the 2nd MEM_WAIT cycle →
  - outputs go immediately to all Write=0 with flushes=1;
  - after deassertion with mem_req=0, defaults and RUN.
